// File: rtl/tl_phase_if.sv
// Sensor/button inputs and lamp/phase outputs of the intersection phase scheduler.
// master = sensor/controller side, slave = scheduler.
interface tl_phase_if;
  logic       side_car;
  logic       ped_btn;
  logic       hold;
  logic       main_r;
  logic       main_y;
  logic       main_g;
  logic       side_r;
  logic       side_y;
  logic       side_g;
  logic       walk;
  logic [2:0] phase;
  logic       phase_end;

  modport master (
    output side_car, ped_btn, hold,
    input  main_r, main_y, main_g, side_r, side_y, side_g, walk, phase, phase_end
  );

  modport slave (
    input  side_car, ped_btn, hold,
    output main_r, main_y, main_g, side_r, side_y, side_g, walk, phase, phase_end
  );
endinterface

// File: rtl/tl_phase_scheduler.sv
// Two-road intersection phase sequencer with pedestrian crossing; owns the single
// phase-duration counter. Main road rests on green, side/walk served on demand.
module tl_phase_scheduler #(
  parameter int MAIN_G_TIME = 8,
  parameter int SIDE_G_TIME = 4,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tl_phase_if.slave   bus
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5
  } state_e;

  localparam logic [7:0] MG_LAST = 8'(MAIN_G_TIME - 1);
  localparam logic [7:0] SG_LAST = 8'(SIDE_G_TIME - 1);
  localparam logic [7:0] Y_LAST  = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AR_LAST = 8'(ALLRED_TIME - 1);

  state_e     state_q, state_d, state_nxt;
  logic [7:0] cnt_q, cnt_d;
  logic       req_pend_q, req_pend_d;
  logic       req, exit_ok, adv, illegal;

  assign req = bus.side_car | bus.ped_btn | req_pend_q;

  // Next-state: exit_ok is the phase's own end condition, adv gates it with hold.
  always_comb begin
    state_nxt = ALL_R2;
    exit_ok   = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      MAIN_G: begin exit_ok = (cnt_q == MG_LAST) && req; state_nxt = MAIN_Y; end
      MAIN_Y: begin exit_ok = (cnt_q == Y_LAST);         state_nxt = ALL_R1; end
      ALL_R1: begin exit_ok = (cnt_q == AR_LAST);        state_nxt = SIDE_G; end
      SIDE_G: begin exit_ok = (cnt_q == SG_LAST);        state_nxt = SIDE_Y; end
      SIDE_Y: begin exit_ok = (cnt_q == Y_LAST);         state_nxt = ALL_R2; end
      ALL_R2: begin exit_ok = (cnt_q == AR_LAST);        state_nxt = MAIN_G; end
      default: illegal = 1'b1;
    endcase

    adv = exit_ok && !bus.hold;

    state_d = state_q;
    if (illegal)  state_d = ALL_R2;
    else if (adv) state_d = state_nxt;
  end

  // Counter clears on entry; MAIN_G saturates so an idle main green never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (illegal || adv)                               cnt_d = 8'd0;
    else if (bus.hold)                                cnt_d = cnt_q;
    else if (state_q == MAIN_G && cnt_q == MG_LAST)   cnt_d = cnt_q;
    else                                              cnt_d = cnt_q + 8'd1;
  end

  // A new request on the SIDE_G entry edge survives the clear.
  always_comb begin
    req_pend_d = req_pend_q;
    if (adv && state_q == ALL_R1) req_pend_d = 1'b0;
    if (bus.side_car || bus.ped_btn) req_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ALL_R2;
      cnt_q      <= 8'd0;
      req_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_pend_q <= req_pend_d;
    end
  end

  always_comb begin
    bus.main_g = (state_q == MAIN_G);
    bus.main_y = (state_q == MAIN_Y);
    bus.main_r = !(bus.main_g || bus.main_y);
    bus.side_g = (state_q == SIDE_G);
    bus.side_y = (state_q == SIDE_Y);
    bus.side_r = !(bus.side_g || bus.side_y);
    bus.walk   = (state_q == SIDE_G);
  end

  assign bus.phase     = state_q;
  // ALL_R2 is the reset state and would otherwise flag its end while in reset.
  assign bus.phase_end = rst_n && adv;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Bench for tl_phase_scheduler: directed scenarios plus random traffic, all
// compared against a phase-table reference model.
module tb_tl_phase_scheduler;
  localparam int MG  = 8;
  localparam int SGT = 4;
  localparam int YT  = 2;
  localparam int AR  = 1;
  localparam logic [10:0] RST_VEC = 11'b100_100_0_101_0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tl_phase_if bus();

  tl_phase_scheduler #(
    .MAIN_G_TIME(MG), .SIDE_G_TIME(SGT), .YELLOW_TIME(YT), .ALLRED_TIME(AR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase index, active cycles spent in it, latched request.
  int m_ph   = 5;
  int m_el   = 0;
  bit m_pend = 1'b0;

  function automatic int dur_of(input int p);
    case (p)
      1, 4:    return YT;
      2, 5:    return AR;
      3:       return SGT;
      default: return MG;
    endcase
  endfunction

  function automatic bit m_done();
    if (m_ph == 0)
      return ((m_el + 1) >= MG) && (bus.side_car || bus.ped_btn || m_pend);
    return (m_el + 1) == dur_of(m_ph);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 5;
      m_el   <= 0;
      m_pend <= 1'b0;
    end else begin
      if (!bus.hold && m_done()) begin
        m_ph <= (m_ph + 1) % 6;
        m_el <= 0;
      end else if (!bus.hold) begin
        m_el <= m_el + 1;
      end
      m_pend <= bus.side_car || bus.ped_btn ||
                (m_pend && !(!bus.hold && m_done() && m_ph == 2));
    end
  end

  function automatic logic [10:0] exp_vec();
    logic mg, my, sg, sy;
    mg = (m_ph == 0); my = (m_ph == 1);
    sg = (m_ph == 3); sy = (m_ph == 4);
    return {!(mg || my), my, mg, !(sg || sy), sy, sg, sg, 3'(m_ph),
            rst_n && !bus.hold && m_done()};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.main_r, bus.main_y, bus.main_g, bus.side_r, bus.side_y, bus.side_g,
            bus.walk, bus.phase, bus.phase_end};
  endfunction

  // One cycle: drive this cycle's inputs just after the edge, sample at negedge.
  task automatic step(input bit sc, input bit pb, input bit hd);
    @(posedge clk);
    #1;
    bus.side_car = sc;
    bus.ped_btn  = pb;
    bus.hold     = hd;
    @(negedge clk);
  endtask

  // Leaves the bench in the ALL_R2 cycle right after reset release.
  task automatic do_reset();
    @(negedge clk);
    bus.side_car = 0; bus.ped_btn = 0; bus.hold = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.side_car = 0; bus.ped_btn = 0; bus.hold = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", dut_vec(), RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.phase !== 3'd5 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%b want=%b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      checks++;
      if (bus.phase !== 3'd0 || bus.main_g !== 1'b1 || bus.phase_end !== 1'b0 ||
          dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL idle_main_g cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_side_car();
    int seq[19] = '{0,0,0,0,0,0,0,0,1,1,2,3,3,3,3,4,4,5,0};
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(i == 1, 0, 0);
      checks++;
      if (bus.phase !== 3'(seq[i]) || bus.walk !== (seq[i] == 3) ||
          dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL side_car_seq i=%0d got=%b want_phase=%0d model=%b",
                 i, dut_vec(), seq[i], exp_vec());
      end
    end
  endtask

  // Continues from MAIN_G entry (cycle 1) left by test_side_car.
  task automatic test_ped_late();
    for (int i = 2; i <= 41; i++) begin
      logic [2:0] wp;
      logic       wpe;
      step(0, i == 30, 0);
      wp  = (i <= 30 || i == 41) ? 3'd0 : (i <= 32 ? 3'd1 : exp_vec()[3:1]);
      wpe = (i == 30) ? 1'b1 : (i < 30 ? 1'b0 : exp_vec()[0]);
      checks++;
      if (bus.phase !== wp || bus.phase_end !== wpe || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ped_late i=%0d got=%b want_phase=%0d want_pe=%b model=%b",
                 i, dut_vec(), wp, wpe, exp_vec());
      end
    end
  endtask

  // Continues from MAIN_G entry; requests during SIDE_G/SIDE_Y serve exactly once more.
  task automatic test_pend_once();
    for (int j = 2; j <= 60; j++) begin
      logic [2:0] wp;
      step(j == 2, (j == 12) || (j == 16), 0);
      if      (j == 12)             wp = 3'd3;
      else if (j == 16)             wp = 3'd4;
      else if (j >= 19 && j <= 26)  wp = 3'd0;
      else if (j == 27)             wp = 3'd1;
      else if (j >= 37)             wp = 3'd0;
      else                          wp = exp_vec()[3:1];
      checks++;
      if (bus.phase !== wp || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL pend_once j=%0d got=%b want_phase=%0d model=%b",
                 j, dut_vec(), wp, exp_vec());
      end
    end
  endtask

  task automatic test_hold();
    int sg_cycles = 0;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      logic [2:0] wp;
      bit         hd;
      hd = (k >= 13 && k <= 17);
      step(k == 2, 0, hd);
      if (bus.phase === 3'd3) sg_cycles++;
      wp = (k >= 12 && k <= 20) ? 3'd3 : (k == 21 ? 3'd4 : exp_vec()[3:1]);
      checks++;
      if (bus.phase !== wp || (hd && (bus.phase_end !== 1'b0 || bus.side_g !== 1'b1 ||
          bus.walk !== 1'b1 || bus.main_r !== 1'b1)) || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL hold k=%0d got=%b want_phase=%0d model=%b",
                 k, dut_vec(), wp, exp_vec());
      end
    end
    checks++;
    if (sg_cycles != 9) begin
      failures++;
      $display("FAIL hold_side_g_len got=%0d want=9", sg_cycles);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 16; k++) step(k == 2, 0, 0);
    checks++;
    if (bus.phase !== 3'd4) begin
      failures++;
      $display("FAIL async_pre got_phase=%0d want=4", bus.phase);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", dut_vec(), RST_VEC);
    end
    bus.side_car = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.phase !== 3'd5 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL async_release got=%b want=%b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      checks++;
      if (bus.phase !== 3'd0 || bus.main_g !== 1'b1 || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL async_after i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 7) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.side_car = 0;
    bus.ped_btn  = 0;
    bus.hold     = 0;
    #1 rst_n = 1'b0;
    test_reset();
    test_side_car();
    test_ped_late();
    test_pend_once();
    test_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_phase_scheduler.md
# tl_phase_scheduler

Phase scheduler for a two-road intersection (main road and side road) with a pedestrian crossing over the main road. Sequences the green / yellow / all-red phases and owns the single shared phase-duration counter, so no separate timer instance is needed. Main road rests on green. The side road and pedestrians are served on demand, after a guaranteed minimum main green. Sits between the sensor/button inputs and the lamp drivers.

## Interface
- `MAIN_G_TIME`, default 8: minimum main-green length in cycles.
- `SIDE_G_TIME`, default 4: fixed side-green / walk length in cycles.
- `YELLOW_TIME`, default 2: yellow length in cycles, both roads.
- `ALLRED_TIME`, default 1: all-red clearance length in cycles.
- All four times are legal in the range 1..255. The counter is 8 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `side_car` in 1: side-road vehicle sensor, level.
- `ped_btn` in 1: pedestrian button, may be a 1-cycle pulse.
- `hold` in 1: freezes sequencing while high.
- `main_r`, `main_y`, `main_g` out 1: main-road lamps.
- `side_r`, `side_y`, `side_g` out 1: side-road lamps.
- `walk` out 1: pedestrian walk lamp.
- `phase` out 3: current state code.
- `phase_end` out 1: high in the last cycle of a phase.

## Operation
- State codes and phase lengths:
  - MAIN_G=0: at least MAIN_G_TIME cycles, unbounded.
  - MAIN_Y=1: YELLOW_TIME cycles.
  - ALL_R1=2: ALLRED_TIME cycles.
  - SIDE_G=3: SIDE_G_TIME cycles.
  - SIDE_Y=4: YELLOW_TIME cycles.
  - ALL_R2=5: ALLRED_TIME cycles.
  - Codes 6 and 7 go to ALL_R2 on the next edge.
- Sequence is fixed: MAIN_G→MAIN_Y→ALL_R1→SIDE_G→SIDE_Y→ALL_R2→MAIN_G.
- Counter `cnt` clears to 0 on every phase entry and increments once per cycle.
- A timed phase of length T exits on the edge after the cycle in which `cnt`==T-1.
- MAIN_G counting: `cnt` saturates at MAIN_G_TIME-1.
- MAIN_G exit: on the edge after a cycle where `cnt`==MAIN_G_TIME-1 and `req` is high.
- `req` = `side_car` | `ped_btn` | `req_pend`.
- `req_pend` register:
  - Set by any cycle with `side_car` or `ped_btn` high.
  - Cleared on the edge entering SIDE_G.
  - If set and clear occur on the same edge, set wins.
  - Result: a request arriving during the entry cycle, SIDE_G, SIDE_Y or ALL_R2 is served in the next cycle of the sequence.
- Lamp decode is combinational from the state register only:
  - Main road: `main_g` in MAIN_G, `main_y` in MAIN_Y, `main_r` in all other states.
  - Side road: `side_g` in SIDE_G, `side_y` in SIDE_Y, `side_r` in all other states.
  - `walk` is high only in SIDE_G.
  - Exactly one lamp per road is high in every cycle.
- `phase_end` = exit condition true and `hold`=0.
- `hold`=1:
  - State and `cnt` are frozen and `phase_end`=0.
  - `req_pend` still sets.
  - On release, sequencing resumes from the frozen `cnt`.
- Reset values: state ALL_R2, `cnt`=0, `req_pend`=0. Outputs: `main_r`=`side_r`=1, all other lamps 0, `walk`=0, `phase`=5, `phase_end`=0.
- Reset asserted mid-phase returns to these values immediately, without waiting for a clock edge.

## Timing
- Phase lengths are exact in cycles as listed; there is no +1 overshoot.
- Lamps change on the same edge as the state.
- After reset release: ALL_R2 for ALLRED_TIME cycles, then MAIN_G.
- Request latency when MAIN_G's minimum has already elapsed: `side_car`/`ped_btn` high in cycle n → MAIN_Y from cycle n+1.
- Request before the minimum has elapsed: MAIN_Y starts exactly MAIN_G_TIME cycles after MAIN_G entry.
- With T=1, `phase_end` is high in the phase's only cycle.
- Full side service with defaults = 2+1+4+2+1 = 10 cycles from MAIN_Y entry back to MAIN_G.

## Test plan
- Reset release with no requests → `phase`=5 for 1 cycle, then `phase`=0 held for 100 cycles, `main_g`=1, `phase_end`=0 throughout.
- `side_car` pulse in cycle 2 of MAIN_G → MAIN_G lasts 8 cycles total. Then `phase` reads 1,1,2,3,3,3,3,4,4,5,0. `walk`=1 only in the four cycles with `phase`=3.
- `ped_btn` 1-cycle pulse at MAIN_G cycle 30 → MAIN_Y on the next cycle, and `phase_end`=1 in the pulse cycle.
- `ped_btn` pulse in the SIDE_G entry cycle, and a second pulse in SIDE_Y → after ALL_R2, MAIN_G lasts exactly 8 cycles, then MAIN_Y (request served once).
- `hold`=1 for 5 cycles in the middle of SIDE_G (`cnt`=1) → `phase`=3 for 9 cycles total, `phase_end`=0 during the hold, lamps unchanged.
- `rst_n` low mid-SIDE_Y, asynchronous to `clk` → lamps immediately go to `main_r`=`side_r`=1 with `phase`=5. After release the bench checks the reset-release sequence again.
